// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run monitor.
package run_monitor_pkg;

   typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} run_state_t;

   localparam int HALT_CODE_W = 32;

endpackage

// File: rtl/run_monitor_if.sv
// Control/status bundle between the run monitor and whatever drives it.
interface run_monitor_if #(
   parameter int CNT_W = 32
) ();
   import run_monitor_pkg::*;

   logic                   i_Start;
   logic                   i_Halt;
   logic [HALT_CODE_W-1:0] i_HaltCode;
   logic                   i_Retire;
   logic                   o_CoreReset;
   logic                   o_Running;
   logic                   o_Done;
   logic                   o_Pass;
   logic                   o_Timeout;
   logic [CNT_W-1:0]       o_CycleCount;
   logic [CNT_W-1:0]       o_RetireCount;
   logic [HALT_CODE_W-1:0] o_HaltCode;

   // Core/testbench side: drives requests, observes status.
   modport master (
      output i_Start, i_Halt, i_HaltCode, i_Retire,
      input  o_CoreReset, o_Running, o_Done, o_Pass, o_Timeout,
             o_CycleCount, o_RetireCount, o_HaltCode
   );

   // Monitor side.
   modport slave (
      input  i_Start, i_Halt, i_HaltCode, i_Retire,
      output o_CoreReset, o_Running, o_Done, o_Pass, o_Timeout,
             o_CycleCount, o_RetireCount, o_HaltCode
   );

endinterface

// File: rtl/run_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         i_Clk,
   input  logic         i_Reset,
   input  logic         i_Clr,
   input  logic         i_Inc,
   output logic [W-1:0] o_Q
);

   logic [W-1:0] r_q;

   // Clear dominates increment; increment is suppressed once all-ones is reached.
   // NOTE: state is updated with <= so every flop samples pre-edge values, never a neighbour's new value.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset)                r_q <= '0;
      else if (i_Clr)              r_q <= '0;
      else if (i_Inc && r_q != '1) r_q <= r_q + W'(1);
   end

   assign o_Q = r_q;

endmodule

// File: rtl/run_monitor.sv
// Run controller: holds the core in reset after a start, counts RUN cycles and
// retired instructions, and ends the run on halt (pass/fail by code) or timeout.
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int                     CNT_W        = 32,
   parameter int                     RESET_CYCLES = 1,
   parameter int                     MAX_CYCLES   = 50,
   parameter logic [HALT_CODE_W-1:0] PASS_CODE    = '0
) (
   input  logic         i_Clk,
   input  logic         i_Reset,
   run_monitor_if.slave bus
);

   // Hold counter only needs to reach RESET_CYCLES; saturation keeps it there.
   localparam int HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

   run_state_t             r_state;
   run_state_t             w_next_state;
   logic [CNT_W-1:0]       r_cycle_count;
   logic                   r_pass;
   logic                   r_timeout;
   logic [HALT_CODE_W-1:0] r_halt_code;
   logic [HOLD_W-1:0]      w_hold_count;
   logic [CNT_W-1:0]       w_retire_count;
   logic                   w_start_ok;
   logic                   w_in_run;
   logic                   w_hold_done;
   logic                   w_budget_end;

   // Start is honoured only when no run is in progress.
   assign w_start_ok   = bus.i_Start && (r_state == IDLE || r_state == DONE);
   assign w_in_run     = (r_state == RUN);
   assign w_hold_done  = (w_hold_count == HOLD_W'(RESET_CYCLES));
   // Evaluated one cycle early so the count lands exactly on MAX_CYCLES in DONE.
   assign w_budget_end = (r_cycle_count == CNT_W'(MAX_CYCLES - 1));

   // State register.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset) r_state <= IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state logic.
   // NOTE: the default assignment up front keeps this purely combinational (no latch) on every path.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE, DONE: if (bus.i_Start)                     w_next_state = RESET;
         RESET:      if (w_hold_done)                     w_next_state = RUN;
         RUN:        if (bus.i_Halt || w_budget_end)      w_next_state = DONE;
         default:                                         w_next_state = IDLE;
      endcase
   end

   // Output decode of the state register.
   always_comb begin
      bus.o_CoreReset = (r_state != RUN);
      bus.o_Running   = (r_state == RUN);
      bus.o_Done      = (r_state == DONE);
   end

   // Cycle counter and end-of-run flags; cleared on an accepted start, frozen outside RUN.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset || w_start_ok) begin
         r_cycle_count <= '0;
         r_pass        <= 1'b0;
         r_timeout     <= 1'b0;
         r_halt_code   <= '0;
      end else if (w_in_run) begin
         r_cycle_count <= r_cycle_count + CNT_W'(1);
         if (bus.i_Halt) begin
            // Halt wins over a coincident budget expiry.
            r_halt_code <= bus.i_HaltCode;
            r_pass      <= (bus.i_HaltCode == PASS_CODE);
            r_timeout   <= 1'b0;
         end else if (w_budget_end) begin
            r_pass      <= 1'b0;
            r_timeout   <= 1'b1;
         end
      end
   end

   sat_counter #(.W(HOLD_W)) u_hold_cnt (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Clr   (w_start_ok),
      .i_Inc   (r_state == RESET),
      .o_Q     (w_hold_count)
   );

   sat_counter #(.W(CNT_W)) u_retire_cnt (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Clr   (w_start_ok),
      .i_Inc   (w_in_run && bus.i_Retire),
      .o_Q     (w_retire_count)
   );

   assign bus.o_Pass        = r_pass;
   assign bus.o_Timeout     = r_timeout;
   assign bus.o_CycleCount  = r_cycle_count;
   assign bus.o_RetireCount = w_retire_count;
   assign bus.o_HaltCode    = r_halt_code;

endmodule
